// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nn_pkg
// Purpose : Shared definitions for the fixed-point neural-network datapath:
//           backward-engine state encoding, default element format, and the
//           shift-and-saturate requantizer shared with the forward linear.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package nn_pkg;

    localparam int C_WIDTH = 16;   // default signed element width
    localparam int C_FRAC  = 8;    // default fractional bits

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } bwd_state_t;

    // Arithmetic right shift by frac (floor toward -inf), then clamp to the
    // signed range of a width-bit element. Operates on a 64-bit container so
    // one function serves every accumulator width up to 64 bits.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 width
    );
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end else begin
            return sh;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_requant.sv
`default_nettype none
// ============================================================================
// Module  : fxp_requant
// Purpose : Combinational requantizer for one gradient element: shift the
//           full-precision sum down by FRAC, saturate to WIDTH bits, and zero
//           it when the matching forward activation was not positive.
// Ports   : acc_i  full-precision accumulated sum (signed, ACC_W bits)
//           fwd_i  forward-pass activation used as the ReLU mask
//           q_o    requantized, masked gradient element
// Rev     : 1.0  initial release
// ============================================================================
module fxp_requant
    import nn_pkg::*;
#(
    parameter int ACC_W = 34,
    parameter int WIDTH = C_WIDTH,
    parameter int FRAC  = C_FRAC
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [WIDTH-1:0] fwd_i,
    output logic signed [WIDTH-1:0] q_o
);

    logic signed [63:0]      w_sat;
    logic                    w_keep;
    logic [63-WIDTH:0]       w_unused_hi;

    // The saturated value always fits in WIDTH bits, so only the low slice
    // is meaningful; the upper bits are pure sign extension.
    assign w_sat       = sat_shift(64'(acc_i), FRAC, WIDTH);
    assign w_unused_hi = w_sat[63:WIDTH];

    // Zero activation counts as masked: keep only strictly positive inputs.
    assign w_keep = !fwd_i[WIDTH-1] && (fwd_i != '0);

    assign q_o = w_keep ? w_sat[WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: rtl/relu_linear_bwd.sv
`default_nettype none
// ============================================================================
// Module  : relu_linear_bwd
// Purpose : Sequential backward pass for a relu -> linear pair. Computes
//           grad_in[i] = mask(fwd_in[i]) * sum_o W[o][i] * grad_out[o]
//           on one time-multiplexed multiply-accumulate, o as inner loop.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           in_valid/in_ready   request handshake (ready only when idle)
//           grad_out            OUT_DIM signed elements, dL/dy
//           weight              OUT_DIM x IN_DIM signed weights, (o,i) at
//                               bits [(o*IN_DIM+i)*WIDTH +: WIDTH]
//           fwd_in              IN_DIM forward activations (mask only)
//           out_valid/out_ready result handshake
//           grad_in             IN_DIM signed elements, dL/dx pre-relu
//           busy                high while multiply-accumulating
// Rev     : 1.0  initial release
// ============================================================================
module relu_linear_bwd
    import nn_pkg::*;
#(
    parameter int IN_DIM  = 32,
    parameter int OUT_DIM = 2,
    parameter int WIDTH   = C_WIDTH,
    parameter int FRAC    = C_FRAC
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [OUT_DIM*WIDTH-1:0]          grad_out,
    input  logic [IN_DIM*OUT_DIM*WIDTH-1:0]   weight,
    input  logic [IN_DIM*WIDTH-1:0]           fwd_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IN_DIM*WIDTH-1:0]           grad_in,
    output logic                              busy
);

    // Sized so a full OUT_DIM-term dot product of WIDTH x WIDTH products
    // can never overflow.
    localparam int ACC_W = 2*WIDTH + $clog2(OUT_DIM) + 1;
    localparam int IW    = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
    localparam int OW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [IW-1:0] C_I_LAST = IW'(IN_DIM - 1);
    localparam logic [OW-1:0] C_O_LAST = OW'(OUT_DIM - 1);

    bwd_state_t                        state_q, state_d;
    logic [IW-1:0]                     i_q, i_d;
    logic [OW-1:0]                     o_q, o_d;
    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [OUT_DIM*WIDTH-1:0]          grad_q;
    logic [IN_DIM*OUT_DIM*WIDTH-1:0]   weight_q;
    logic [IN_DIM*WIDTH-1:0]           fwd_q;
    logic [IN_DIM*WIDTH-1:0]           grad_in_q;

    logic                              w_accept;
    logic                              w_wr;
    logic signed [WIDTH-1:0]           w_w;
    logic signed [WIDTH-1:0]           w_g;
    logic signed [WIDTH-1:0]           w_f;
    logic signed [2*WIDTH-1:0]         w_prod;
    logic signed [ACC_W-1:0]           w_sum;
    logic signed [WIDTH-1:0]           w_q;

    // ---------------------------------------------------------------- datapath
    assign w_w = weight_q[(int'(o_q)*IN_DIM + int'(i_q))*WIDTH +: WIDTH];
    assign w_g = grad_q[int'(o_q)*WIDTH +: WIDTH];
    assign w_f = fwd_q[int'(i_q)*WIDTH +: WIDTH];

    assign w_prod = (2*WIDTH)'(w_w) * (2*WIDTH)'(w_g);
    assign w_sum  = acc_q + ACC_W'(w_prod);

    fxp_requant #(
        .ACC_W (ACC_W),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_requant (
        .acc_i (w_sum),
        .fwd_i (w_f),
        .q_o   (w_q)
    );

    // ------------------------------------------------------- next-state logic
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        o_d      = o_q;
        acc_d    = acc_q;
        w_accept = 1'b0;
        w_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    acc_d    = '0;
                    i_d      = '0;
                    o_d      = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                if (o_q == C_O_LAST) begin
                    // Last term of this element: the write uses acc + product
                    // directly, so the accumulator restarts clean for i+1.
                    w_wr  = 1'b1;
                    acc_d = '0;
                    o_d   = '0;
                    if (i_q == C_I_LAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    acc_d = w_sum;
                    o_d   = o_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            o_q       <= '0;
            acc_q     <= '0;
            grad_q    <= '0;
            weight_q  <= '0;
            fwd_q     <= '0;
            grad_in_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            acc_q   <= acc_d;
            if (w_accept) begin
                grad_q   <= grad_out;
                weight_q <= weight;
                fwd_q    <= fwd_in;
            end
            if (w_wr) begin
                grad_in_q[int'(i_q)*WIDTH +: WIDTH] <= w_q;
            end
        end
    end

    // Status outputs decode the state register only.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MAC);
    assign out_valid = (state_q == DONE);
    assign grad_in   = grad_in_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_linear_bwd.sv
`default_nettype none
// ============================================================================
// Module  : tb_relu_linear_bwd
// Purpose : Directed, table-driven bench for relu_linear_bwd at IN_DIM=4,
//           OUT_DIM=2, WIDTH=16, FRAC=8 (1.0 = 256), plus hand-written
//           sequences for output back-pressure and mid-MAC reset.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_relu_linear_bwd;

    localparam int IN_DIM  = 4;
    localparam int OUT_DIM = 2;
    localparam int WIDTH   = 16;
    localparam int FRAC    = 8;
    localparam int NV      = 7;
    localparam int LAT     = IN_DIM * OUT_DIM;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            in_valid;
    logic                            in_ready;
    logic [OUT_DIM*WIDTH-1:0]        grad_out;
    logic [IN_DIM*OUT_DIM*WIDTH-1:0] weight;
    logic [IN_DIM*WIDTH-1:0]         fwd_in;
    logic                            out_valid;
    logic                            out_ready;
    logic [IN_DIM*WIDTH-1:0]         grad_in;
    logic                            busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [OUT_DIM*WIDTH-1:0]        g;
        logic [IN_DIM*OUT_DIM*WIDTH-1:0] w;
        logic [IN_DIM*WIDTH-1:0]         f;
        logic [IN_DIM*WIDTH-1:0]         e;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    relu_linear_bwd #(
        .IN_DIM  (IN_DIM),
        .OUT_DIM (OUT_DIM),
        .WIDTH   (WIDTH),
        .FRAC    (FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grad_out  (grad_out),
        .weight    (weight),
        .fwd_in    (fwd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_in   (grad_in),
        .busy      (busy)
    );

    function automatic logic [31:0] p2(input int a, input int b);
        return {16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Row o=0 in the low half, row o=1 in the high half.
    function automatic logic [127:0] w8(input int a0, input int a1, input int a2, input int a3,
                                        input int b0, input int b1, input int b2, input int b3);
        return {p4(b0, b1, b2, b3), p4(a0, a1, a2, a3)};
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_grad(input int tag, input logic [63:0] e);
        for (int k = 0; k < IN_DIM; k++) begin
            chk($sformatf("v%0d grad_in[%0d]", tag, k),
                $signed(grad_in[k*WIDTH +: WIDTH]), $signed(e[k*WIDTH +: WIDTH]));
        end
    endtask

    // Present a request, scramble the inputs after acceptance, and return
    // the number of rising edges from accept until out_valid is seen.
    task automatic send(input vec_t v, input int tag, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        grad_out = v.g;
        weight   = v.w;
        fwd_in   = v.f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        grad_out = $urandom;
        weight   = {$urandom, $urandom, $urandom, $urandom};
        fwd_in   = {$urandom, $urandom};
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                chk($sformatf("v%0d busy in MAC", tag), 32'(busy), 1);
                chk($sformatf("v%0d in_ready in MAC", tag), 32'(in_ready), 0);
            end
        end while (!out_valid && lat < 100);
    endtask

    task automatic handshake(input int tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d in_ready after handshake", tag), 32'(in_ready), 1);
        chk($sformatf("v%0d out_valid after handshake", tag), 32'(out_valid), 0);
    endtask

    initial begin
        int lat;
        logic [IN_DIM*WIDTH-1:0] saved;

        vecs[0] = '{g: p2(256, 128), w: w8(256, 256, 256, 256, 512, 512, 512, 512),
                    f: p4(256, 256, 256, 256), e: p4(512, 512, 512, 512)};
        vecs[1] = '{g: p2(256, 128), w: w8(256, 256, 256, 256, 512, 512, 512, 512),
                    f: p4(256, 0, -256, 1), e: p4(512, 0, 0, 512)};
        vecs[2] = '{g: p2(32512, 32512),
                    w: w8(32512, 32512, 32512, 32512, 32512, 32512, 32512, 32512),
                    f: p4(256, 256, 256, 256), e: p4(32767, 32767, 32767, 32767)};
        vecs[3] = '{g: p2(-32512, -32512),
                    w: w8(32512, 32512, 32512, 32512, 32512, 32512, 32512, 32512),
                    f: p4(256, 256, 256, 256), e: p4(-32768, -32768, -32768, -32768)};
        vecs[4] = '{g: p2(1, 0), w: w8(1, 1, 1, 1, 0, 0, 0, 0),
                    f: p4(256, 256, 256, 256), e: p4(0, 0, 0, 0)};
        vecs[5] = '{g: p2(-1, 0), w: w8(1, 1, 1, 1, 0, 0, 0, 0),
                    f: p4(256, 256, 256, 256), e: p4(-1, -1, -1, -1)};
        vecs[6] = '{g: p2(512, 256), w: w8(256, -256, 128, 0, 0, 256, 256, -512),
                    f: p4(1, 1, 1, 1), e: p4(512, -256, 512, -512)};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        grad_out  = '0;
        weight    = '0;
        fwd_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset grad_in zero", 32'(grad_in == '0), 1);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int v = 0; v < NV; v++) begin
            send(vecs[v], v, lat);
            chk($sformatf("v%0d latency", v), lat, LAT);
            chk_grad(v, vecs[v].e);
            handshake(v);
        end

        // Back-pressure: hold out_ready low and try to sneak in a request.
        send(vecs[0], 100, lat);
        chk("bp latency", lat, LAT);
        chk_grad(100, vecs[0].e);
        saved = grad_in;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = (c == 5 || c == 6);
            grad_out = vecs[2].g;
            weight   = vecs[2].w;
            fwd_in   = vecs[2].f;
            chk($sformatf("bp c%0d out_valid", c), 32'(out_valid), 1);
            chk($sformatf("bp c%0d in_ready", c), 32'(in_ready), 0);
            chk($sformatf("bp c%0d grad_in stable", c), 32'(grad_in == saved), 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake(101);
        repeat (3) @(negedge clk);
        chk("bp no stray accept busy", 32'(busy), 0);
        chk("bp no stray accept in_ready", 32'(in_ready), 1);
        chk("bp grad_in kept", 32'(grad_in == saved), 1);

        // Asynchronous reset during MAC cycle 3 of a request.
        @(negedge clk);
        in_valid = 1'b1;
        grad_out = vecs[6].g;
        weight   = vecs[6].w;
        fwd_in   = vecs[6].f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst-mid busy before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst-mid out_valid", 32'(out_valid), 0);
        chk("rst-mid busy", 32'(busy), 0);
        chk("rst-mid in_ready", 32'(in_ready), 1);
        chk("rst-mid grad_in zero", 32'(grad_in == '0), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst-mid in_ready after release", 32'(in_ready), 1);
        send(vecs[0], 200, lat);
        chk("post-rst latency", lat, LAT);
        chk_grad(200, vecs[0].e);
        handshake(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/relu_linear_bwd.md
# relu_linear_bwd

Sequential backward-pass engine for one fixed-point `linear` layer that is fed by a `relu`. It accepts the gradient with respect to the layer output, the layer weights, and the forward-pass layer input, and returns the gradient with respect to the pre-ReLU activation: grad_in[i] = mask(fwd_in[i]) · Σ_o W[o][i]·grad_out[o]. It runs on a single multiply-accumulate time-multiplexed over all weights. It is the training-direction counterpart of the combinational inference MLP and is instantiated once per layer, or reused across layers, in the backprop datapath.

## Interface
- `IN_DIM`, 32: layer input width, which is also the gradient output length.
- `OUT_DIM`, 2: layer output width, which is also the gradient input length.
- `WIDTH`, 16: signed fixed-point element width.
- `FRAC`, 8: fractional bits (Q(WIDTH-FRAC).FRAC).
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request carries a valid operand set.
- `in_ready`  out  1  engine idle and able to accept a request.
- `grad_out`  in  OUT_DIM*WIDTH  signed dL/dy; element o occupies bits [o*WIDTH +: WIDTH].
- `weight`  in  IN_DIM*OUT_DIM*WIDTH  signed W; element (o,i) occupies bits [(o*IN_DIM+i)*WIDTH +: WIDTH].
- `fwd_in`  in  IN_DIM*WIDTH  signed forward-pass layer input (the ReLU output); used only as a mask.
- `out_valid`  out  1  `grad_in` is complete.
- `out_ready`  in  1  consumer accepts `grad_in`.
- `grad_in`  out  IN_DIM*WIDTH  signed dL/dx_pre-relu, using the same element layout as `fwd_in`.
- `busy`  out  1  engine is in state MAC.

## Operation
- States are IDLE, MAC and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `grad_out`, `weight` and `fwd_in` into internal operand registers.
  - Clear the accumulator, set i=0 and o=0, and go to MAC.
  - Inputs may change freely after acceptance.
- **MAC**
  - One MAC per cycle, with o as the inner loop: acc_next = acc + W[o][i]·grad_out[o].
  - The full-precision accumulator width is 2*WIDTH + clog2(OUT_DIM) + 1; it never overflows.
  - When o = OUT_DIM-1, the sum (acc + product) is requantized and written to grad_in[i] in the same cycle. The accumulator is then cleared, o resets to 0 and i increments.
  - Requantize:
    - Arithmetic shift right by FRAC, which truncates toward −∞.
    - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
    - If fwd_in[i] ≤ 0, force the result to 0 (zero counts as masked).
  - After the write for i = IN_DIM-1, go to DONE.
  - No skipping of masked elements: the cycle count is fixed.
- **DONE**
  - `out_valid`=1 and `grad_in` is held stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored here: `in_ready`=0 in MAC and DONE.
- **Reset**, asserted at any time including mid-MAC:
  - State goes to IDLE and all counters, the accumulator, the operand registers and `grad_in` clear to 0.
  - `out_valid`=0, `busy`=0, and `in_ready`=1 once the state is IDLE.
  - A partial result is discarded and never presented.

## Timing
- Accept edge is cycle 0. MAC occupies cycles 1..IN_DIM*OUT_DIM. `out_valid` rises after the edge that ends the last MAC cycle.
- Latency from accept edge to `out_valid` is IN_DIM*OUT_DIM cycles (64 at defaults).
- The output handshake completes on the edge where `out_valid && out_ready`. `in_ready` is 1 in the following cycle.
- Minimum initiation interval is IN_DIM*OUT_DIM + 2 cycles.
- `in_ready`, `out_valid` and `busy` are decoded directly from state registers, with no combinational path from inputs.
- `grad_in` changes only during MAC writes or reset.

## Structure
- Shared package `nn_pkg` holds:
  - the state enum `bwd_state_t` (IDLE, MAC, DONE);
  - the default `WIDTH`/`FRAC` constants;
  - the function `sat_shift(acc, FRAC, WIDTH)`, shared with the forward `linear`.
- One natural sub-module: `fxp_requant`, a combinational shift + saturate + mask unit, instanced once on the MAC write path.
- The counters i (clog2 IN_DIM) and o (clog2 OUT_DIM) live in the top module.

## Test plan
All scenarios use IN_DIM=4, OUT_DIM=2, WIDTH=16, FRAC=8 (1.0 = 256).
1. W[0][*]=256, W[1][*]=512, grad_out=[256,128], fwd_in all 256 -> grad_in=[512,512,512,512]; `out_valid` rises exactly 8 cycles after the accept edge.
2. Same as scenario 1 but fwd_in=[256,0,−256,1] -> grad_in=[512,0,0,512].
3. W all 32512, grad_out=[32512,32512] -> every element is 32767. With grad_out=[−32512,−32512] -> every element is −32768.
4. W[0][*]=1, W[1][*]=0. grad_out=[1,0] -> all elements 0. grad_out=[−1,0] -> all elements −1 (truncation toward −∞).
5. Hold `out_ready`=0 for 20 cycles after `out_valid`, and pulse `in_valid` with new operands during that window -> `out_valid` stays 1, `grad_in` is unchanged, `in_ready`=0 and the new request is not accepted. Raising `out_ready` -> `in_ready`=1 on the next cycle.
6. Assert `rst` asynchronously during MAC cycle 3 -> immediately `out_valid`=0, `busy`=0 and `grad_in`=0. After release, `in_ready`=1 and a fresh scenario-1 request returns [512,512,512,512].
